// File: rtl/draw_cmd_pkg.sv
// -----------------------------------------------------------------------------
// draw_cmd_pkg
// Shared types and constants for the SPI draw-command decoder.
//   draw_cmd_op_t : decoded command opcode (CMD_NONE marks an unknown byte)
//   draw_cmd_t    : fixed-format draw command handed to the drawing manager
//   OPC_* / LEN_* : opcode byte values and payload byte counts
// -----------------------------------------------------------------------------
package draw_cmd_pkg;

  typedef enum logic [1:0] {
    CMD_NONE      = 2'd0,
    CMD_CLEAR     = 2'd1,
    CMD_TRIANGLE  = 2'd2,
    CMD_FRAME_END = 2'd3
  } draw_cmd_op_t;

  typedef struct packed {
    draw_cmd_op_t op;
    logic [11:0]  color;
    logic [7:0]   v0x;
    logic [7:0]   v0y;
    logic [7:0]   v1x;
    logic [7:0]   v1y;
    logic [7:0]   v2x;
    logic [7:0]   v2y;
  } draw_cmd_t;

  localparam logic [7:0] OPC_CLEAR     = 8'h01;
  localparam logic [7:0] OPC_TRIANGLE  = 8'h02;
  localparam logic [7:0] OPC_FRAME_END = 8'h03;

  localparam logic [3:0] LEN_CLEAR     = 4'd2;
  localparam logic [3:0] LEN_TRIANGLE  = 4'd8;
  localparam logic [3:0] LEN_FRAME_END = 4'd0;

  // Maps a received byte onto an opcode; anything unrecognised is CMD_NONE.
  function automatic draw_cmd_op_t decode_opcode(input logic [7:0] b);
    case (b)
      OPC_CLEAR:     decode_opcode = CMD_CLEAR;
      OPC_TRIANGLE:  decode_opcode = CMD_TRIANGLE;
      OPC_FRAME_END: decode_opcode = CMD_FRAME_END;
      default:       decode_opcode = CMD_NONE;
    endcase
  endfunction

  function automatic logic [3:0] payload_len(input draw_cmd_op_t op);
    case (op)
      CMD_CLEAR:    payload_len = LEN_CLEAR;
      CMD_TRIANGLE: payload_len = LEN_TRIANGLE;
      default:      payload_len = LEN_FRAME_END;
    endcase
  endfunction

endpackage

// File: rtl/draw_cmd_decoder_fifo.sv
// -----------------------------------------------------------------------------
// cmd_fifo
// Generic first-word-fall-through FIFO. The head entry is visible on
// pop_data_o whenever pop_valid_o is high; it reads as zero when empty.
//   clk_system / rstn_system : clock, asynchronous active-low reset
//   push_i, push_data_i      : write request and payload
//   push_ready_o             : write will be accepted this cycle
//   pop_valid_o, pop_ready_i : head valid / consumer takes the head
//   pop_data_o               : head payload
// -----------------------------------------------------------------------------
module cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = logic [7:0]
) (
  input  logic clk_system,
  input  logic rstn_system,
  input  logic push_i,
  input  T     push_data_i,
  output logic push_ready_o,
  output logic pop_valid_o,
  input  logic pop_ready_i,
  output T     pop_data_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             pop;
  logic             push_accept;

  assign pop_valid_o  = (count_q != '0);
  assign pop          = pop_valid_o && pop_ready_i;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign push_ready_o = (count_q < (PTR_W+1)'(DEPTH)) || pop;
  assign push_accept  = push_i && push_ready_o;
  assign pop_data_o   = pop_valid_o ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointers are log2(DEPTH) wide, so they wrap naturally.
    if (push_accept) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)         rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_accept, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_system or negedge rstn_system) begin
    if (!rstn_system) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; count_q gates its visibility, so stale words are never seen.
  always_ff @(posedge clk_system) begin
    if (push_accept) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/draw_cmd_decoder.sv
// -----------------------------------------------------------------------------
// draw_cmd_decoder
// Assembles opcode-prefixed packets from the SPI rx byte stream into draw
// commands and queues them for the drawing manager. Unknown opcodes, stalled
// packets and commands that find the queue full are dropped and counted.
//   clk_system / rstn_system : system clock, asynchronous active-low reset
//   rx_valid, rx_data        : one-cycle byte strobe and byte from SPI
//   cmd_valid, cmd_ready     : queue head valid / drawing manager takes it
//   cmd                      : queue head command
//   err_count                : saturating count of dropped packets/bytes
//   busy                     : parser is in the middle of a packet
// -----------------------------------------------------------------------------
module draw_cmd_decoder
  import draw_cmd_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clk_system,
  input  logic       rstn_system,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output draw_cmd_t  cmd,
  output logic [7:0] err_count,
  output logic       busy
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_PUSH    = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      byte_cnt_q, byte_cnt_d;
  draw_cmd_t       asm_q, asm_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]      err_q, err_d;
  logic [1:0]      err_inc;
  logic [9:0]      err_sum;
  logic            fifo_push;
  logic            fifo_ready;
  draw_cmd_op_t    rx_op;

  assign rx_op     = decode_opcode(rx_data);
  assign busy      = (state_q != ST_IDLE);
  assign err_count = err_q;

  // Parser next-state. IDLE and PUSH share opcode handling so a byte that
  // arrives during PUSH starts the next packet instead of being lost.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    fifo_push  = 1'b0;
    err_inc    = 2'd0;

    case (state_q)
      ST_IDLE, ST_PUSH: begin
        if (state_q == ST_PUSH) begin
          fifo_push = 1'b1;
          if (!fifo_ready) err_inc = err_inc + 2'd1;
          state_d = ST_IDLE;
        end
        if (rx_valid) begin
          if (rx_op == CMD_NONE) begin
            err_inc = err_inc + 2'd1;
            state_d = ST_IDLE;
          end else begin
            // Fields the opcode does not carry stay zero.
            asm_d      = '0;
            asm_d.op   = rx_op;
            byte_cnt_d = payload_len(rx_op);
            state_d    = (payload_len(rx_op) == 4'd0) ? ST_PUSH : ST_PAYLOAD;
          end
        end
      end

      ST_PAYLOAD: begin
        if (rx_valid) begin
          // byte_cnt counts down, so the field order is fixed for all opcodes.
          case (byte_cnt_q)
            4'd8:    asm_d.v0x          = rx_data;
            4'd7:    asm_d.v0y          = rx_data;
            4'd6:    asm_d.v1x          = rx_data;
            4'd5:    asm_d.v1y          = rx_data;
            4'd4:    asm_d.v2x          = rx_data;
            4'd3:    asm_d.v2y          = rx_data;
            4'd2:    asm_d.color[11:8]  = rx_data[3:0];
            4'd1:    asm_d.color[7:0]   = rx_data;
            default: asm_d              = asm_q;
          endcase
          byte_cnt_d = byte_cnt_q - 4'd1;
          if (byte_cnt_q == 4'd1) state_d = ST_PUSH;
        end else if (to_cnt_q == TO_LAST) begin
          // Stalled packet: an rx byte on this same cycle would have won.
          state_d = ST_IDLE;
          err_inc = 2'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Idle-cycle counter only runs while waiting for payload bytes.
  always_comb begin
    if (rx_valid || (state_q != ST_PAYLOAD)) to_cnt_d = '0;
    else                                     to_cnt_d = to_cnt_q + TO_W'(1);
  end

  // Up to two drops can land in one cycle (full FIFO in PUSH plus an unknown
  // opcode), so the increment is added and then clamped at 255.
  always_comb begin
    err_sum = {2'b00, err_q} + {8'd0, err_inc};
    err_d   = (err_sum > 10'd255) ? 8'hFF : err_sum[7:0];
  end

  always_ff @(posedge clk_system or negedge rstn_system) begin
    if (!rstn_system) begin
      state_q    <= ST_IDLE;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      to_cnt_q   <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      to_cnt_q   <= to_cnt_d;
      err_q      <= err_d;
    end
  end

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (draw_cmd_t)
  ) u_cmd_fifo (
    .clk_system   (clk_system),
    .rstn_system  (rstn_system),
    .push_i       (fifo_push),
    .push_data_i  (asm_q),
    .push_ready_o (fifo_ready),
    .pop_valid_o  (cmd_valid),
    .pop_ready_i  (cmd_ready),
    .pop_data_o   (cmd)
  );

endmodule

// File: tb/tb_draw_cmd_decoder.sv
// -----------------------------------------------------------------------------
// tb_draw_cmd_decoder
// Directed bench for draw_cmd_decoder. Expected commands are queued when the
// stimulus is driven and compared as the drawing-manager side pops them.
// -----------------------------------------------------------------------------
module tb_draw_cmd_decoder;
  import draw_cmd_pkg::*;

  localparam int unsigned FIFO_DEPTH     = 4;
  localparam int unsigned TIMEOUT_CYCLES = 16;

  logic       clk_system = 1'b0;
  logic       rstn_system;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       cmd_valid;
  logic       cmd_ready;
  draw_cmd_t  cmd;
  logic [7:0] err_count;
  logic       busy;

  int        n_checks = 0;
  int        n_fail   = 0;
  int        n_pops   = 0;
  int        pops_before;
  draw_cmd_t exp_q [$];
  draw_cmd_t mon_exp;

  always #5 clk_system = ~clk_system;

  draw_cmd_decoder #(
    .FIFO_DEPTH     (FIFO_DEPTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk_system  (clk_system),
    .rstn_system (rstn_system),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd         (cmd),
    .err_count   (err_count),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic draw_cmd_t mk(input draw_cmd_op_t op, input logic [11:0] color,
                                   input logic [7:0] ax, input logic [7:0] ay,
                                   input logic [7:0] bx, input logic [7:0] by,
                                   input logic [7:0] cx, input logic [7:0] cy);
    draw_cmd_t c;
    c.op = op; c.color = color;
    c.v0x = ax; c.v0y = ay; c.v1x = bx; c.v1y = by; c.v2x = cx; c.v2y = cy;
    return c;
  endfunction

  task automatic tick();
    @(posedge clk_system);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic sample();
    @(negedge clk_system);
  endtask

  // Scoreboard side: every handshake pops one expected command.
  always @(negedge clk_system) begin
    if (rstn_system === 1'b1 && cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
      n_pops++;
      check("sb_expected_pending", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        check("cmd_content", 64'(cmd), 64'(mon_exp));
      end
    end
  end

  initial begin
    draw_cmd_t fe;
    fe = mk(CMD_FRAME_END, 12'h000, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    rstn_system = 1'b0;
    rx_valid    = 1'b0;
    rx_data     = 8'h00;
    cmd_ready   = 1'b1;

    // Reset state
    #12;
    check("rst_cmd_valid", 64'(cmd_valid), 64'd0);
    check("rst_cmd",       64'(cmd),       64'd0);
    check("rst_err_count", 64'(err_count), 64'd0);
    check("rst_busy",      64'(busy),      64'd0);
    tick();
    rstn_system = 1'b1;
    idle(2);

    // CLEAR with exact latency: PUSH one cycle after the last byte, valid after that
    exp_q.push_back(mk(CMD_CLEAR, 12'hABC, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0));
    send(8'h01); send(8'hFA); send(8'hBC);
    sample();
    check("clear_busy_in_push", 64'(busy),      64'd1);
    check("clear_valid_n1",     64'(cmd_valid), 64'd0);
    tick(); sample();
    check("clear_valid_n2",     64'(cmd_valid), 64'd1);
    tick(); sample();
    check("clear_valid_n3",     64'(cmd_valid), 64'd0);
    check("clear_busy_after",   64'(busy),      64'd0);

    // TRIANGLE
    exp_q.push_back(mk(CMD_TRIANGLE, 12'hF00, 8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60));
    send(8'h02);
    sample();
    check("tri_busy", 64'(busy), 64'd1);
    send(8'd10); send(8'd20); send(8'd30); send(8'd40);
    send(8'd50); send(8'd60); send(8'h0F); send(8'h00);
    idle(4);

    // Unknown opcode dropped, following FRAME_END decoded
    exp_q.push_back(fe);
    send(8'h7E); send(8'h03);
    idle(4); sample();
    check("unknown_err_count", 64'(err_count), 64'd1);

    // Timeout after 16 idle cycles mid-packet
    send(8'h02); send(8'h05);
    idle(15); sample();
    check("to_busy_before_expiry", 64'(busy),      64'd1);
    check("to_err_before_expiry",  64'(err_count), 64'd1);
    tick(); sample();
    check("to_busy_after_expiry",  64'(busy),      64'd0);
    check("to_err_after_expiry",   64'(err_count), 64'd2);
    exp_q.push_back(fe);
    send(8'h03);
    idle(4);

    // Byte landing exactly on the expiry cycle is accepted
    exp_q.push_back(mk(CMD_CLEAR, 12'hACD, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0));
    send(8'h01); send(8'h0A);
    idle(15);
    send(8'hCD);
    idle(3); sample();
    check("expiry_byte_err_count", 64'(err_count), 64'd2);
    check("expiry_byte_busy",      64'(busy),      64'd0);
    check("expiry_byte_drained",   64'(exp_q.size()), 64'd0);

    // Overflow: five FRAME_ENDs into a depth-4 FIFO with no consumer
    cmd_ready = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back(fe);
    for (int i = 0; i < 5; i++) send(8'h03);
    idle(3); sample();
    check("ovf_err_count",  64'(err_count), 64'd3);
    check("ovf_cmd_valid",  64'(cmd_valid), 64'd1);
    check("ovf_head_stable", 64'(cmd),      64'(fe));

    // Sixth FRAME_END pushed in the same cycle as the first pop
    pops_before = n_pops;
    exp_q.push_back(fe);
    tick();
    send(8'h03);
    cmd_ready = 1'b1;
    idle(8); sample();
    check("ovf_push_with_pop_err", 64'(err_count),          64'd3);
    check("ovf_drain_count",       64'(n_pops - pops_before), 64'd5);
    check("ovf_drained",           64'(exp_q.size()),        64'd0);

    // Reset mid-TRIANGLE with two commands queued
    cmd_ready = 1'b0;
    exp_q.push_back(fe); exp_q.push_back(fe);
    send(8'h03); send(8'h03);
    idle(2);
    send(8'h02); send(8'h01); send(8'h02);
    sample();
    check("pre_rst_busy",      64'(busy),      64'd1);
    check("pre_rst_cmd_valid", 64'(cmd_valid), 64'd1);
    tick();
    rstn_system = 1'b0;
    #1;
    check("mid_rst_cmd_valid", 64'(cmd_valid), 64'd0);
    check("mid_rst_err_count", 64'(err_count), 64'd0);
    check("mid_rst_busy",      64'(busy),      64'd0);
    check("mid_rst_cmd",       64'(cmd),       64'd0);
    exp_q.delete();
    idle(2);
    rstn_system = 1'b1;
    cmd_ready   = 1'b1;
    idle(1);

    // Fresh CLEAR after reset; high nibble of the first color byte is ignored
    exp_q.push_back(mk(CMD_CLEAR, 12'h234, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0));
    send(8'h01); send(8'h12); send(8'h34);
    idle(4); sample();
    check("post_rst_drained",   64'(exp_q.size()), 64'd0);
    check("post_rst_err_count", 64'(err_count),    64'd0);
    check("post_rst_cmd_valid", 64'(cmd_valid),    64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
